// File: rtl/nbcac_pkg.sv
// Shared NBCAC definitions: Fibonacci numbers, codeword sizing and wire weights.
package nbcac_pkg;

  localparam int unsigned WMAX = 64;
  typedef logic [WMAX-1:0] wide_t;

  // Fibonacci with F(0)=0, F(1)=F(2)=1.
  function automatic wide_t fib(input int unsigned n);
    wide_t a;
    wide_t b;
    wide_t t;
    a = '0;
    b = wide_t'(1);
    if (n == 0) return '0;
    for (int unsigned i = 1; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Smallest wire count N whose largest codeable value 2*F(N+1)-1 covers 2^data_w words.
  function automatic int unsigned code_w(input int unsigned data_w);
    int unsigned n;
    n = 2;
    while (((fib(n + 1) << 1) - wide_t'(1)) < (wide_t'(1) << data_w)) n++;
    return n;
  endfunction

  // Weight of wire k (1-based): w[1]=1, w[k]=2*F(cw+1-k).
  function automatic wide_t weight(input int unsigned k, input int unsigned cw);
    if (k <= 1) return wide_t'(1);
    if (k > cw) return '0;
    return fib(cw + 1 - k) << 1;
  endfunction

endpackage

// File: rtl/nbcac_enc_stage.sv
// Combinational slice of K consecutive NBCAC decisions starting at wire FIRST_K.
module nbcac_enc_stage
  import nbcac_pkg::*;
#(
  parameter int unsigned FIRST_K = 2,
  parameter int unsigned K       = 1,
  parameter int unsigned CODE_W  = 21,
  parameter int unsigned RW      = 16
) (
  input  logic [RW-1:0]     rem,
  input  logic [CODE_W-1:0] code,
  input  logic              prev,
  output logic [RW-1:0]     nxt_rem,
  output logic [CODE_W-1:0] nxt_code,
  output logic              nxt_prev
);

  localparam int unsigned RW1 = RW + 1;

  if (K == 0) begin : g_pass
    assign nxt_rem  = rem;
    assign nxt_code = code;
    assign nxt_prev = prev;
  end else begin : g_dec
    logic [RW-1:0]     r;
    logic [CODE_W-1:0] c;
    logic              p;
    logic              d;
    logic [RW:0]       wk;
    logic [RW:0]       wsum;

    always_comb begin
      r    = rem;
      c    = code;
      p    = prev;
      d    = 1'b0;
      wk   = '0;
      wsum = '0;
      for (int unsigned j = 0; j < K; j++) begin
        if (FIRST_K + j >= CODE_W) begin
          d = (r != '0);
        end else begin
          wk   = RW1'(weight(FIRST_K + j, CODE_W));
          wsum = wk + RW1'(weight(FIRST_K + j + 1, CODE_W));
          // set if the rest can't fit below, clear if below w[k], otherwise follow the neighbour
          d = ({1'b0, r} >= wsum) | (({1'b0, r} >= wk) & p);
          if (d) r = r - wk[RW-1:0];
        end
        c[FIRST_K + j - 1] = d;
        p = d;
      end
    end

    assign nxt_rem  = r;
    assign nxt_code = c;
    assign nxt_prev = p;
  end

endmodule

// File: rtl/nbcac_encoder_pipe.sv
// Pipelined NBCAC encoder: DATA_W-bit word to CODE_W-wire codeword, valid/ready, bus hold.
module nbcac_encoder_pipe
  import nbcac_pkg::*;
#(
  parameter int unsigned DATA_W = 15,
  parameter int unsigned CODE_W = code_w(DATA_W),
  parameter int unsigned STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code
);

  localparam int unsigned RW  = DATA_W + 1;
  localparam int unsigned PER = (CODE_W + STAGES - 2) / STAGES;

  typedef struct packed {
    logic              valid;
    logic [RW-1:0]     rem;
    logic [CODE_W-1:0] code;
    logic              prev;
  } stage_t;

  function automatic int unsigned stage_first(input int unsigned s);
    return 2 + s * PER;
  endfunction

  function automatic int unsigned stage_k(input int unsigned s);
    if (stage_first(s) > CODE_W) return 0;
    if (stage_first(s) + PER - 1 > CODE_W) return CODE_W + 1 - stage_first(s);
    return PER;
  endfunction

  stage_t            st [STAGES];
  logic [STAGES:0]   ready;
  logic [STAGES-1:0] nx_valid;
  logic [RW-1:0]     sl_rem_in   [STAGES];
  logic [RW-1:0]     sl_rem_out  [STAGES];
  logic [CODE_W-1:0] sl_code_in  [STAGES];
  logic [CODE_W-1:0] sl_code_out [STAGES];
  logic [STAGES-1:0] sl_prev_in;
  logic [STAGES-1:0] sl_prev_out;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      // d[1] = v[0]; the remainder v - d[1] is just v with bit 0 cleared
      assign nx_valid[0]   = in_valid;
      assign sl_rem_in[0]  = {1'b0, in_data[DATA_W-1:1], 1'b0};
      assign sl_code_in[0] = {{(CODE_W-1){1'b0}}, in_data[0]};
      assign sl_prev_in[0] = in_data[0];
    end else begin : g_body
      assign nx_valid[s]   = st[s-1].valid;
      assign sl_rem_in[s]  = st[s-1].rem;
      assign sl_code_in[s] = st[s-1].code;
      assign sl_prev_in[s] = st[s-1].prev;
    end

    nbcac_enc_stage #(
      .FIRST_K(stage_first(s)),
      .K      (stage_k(s)),
      .CODE_W (CODE_W),
      .RW     (RW)
    ) u_slice (
      .rem     (sl_rem_in[s]),
      .code    (sl_code_in[s]),
      .prev    (sl_prev_in[s]),
      .nxt_rem (sl_rem_out[s]),
      .nxt_code(sl_code_out[s]),
      .nxt_prev(sl_prev_out[s])
    );
  end

  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int unsigned s = STAGES; s > 0; s--) ready[s-1] = ready[s] | ~st[s-1].valid;
  end

  assign in_ready = ready[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) st[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (ready[s]) begin
          st[s].valid <= nx_valid[s];
          // bubbles leave data untouched so the output wires hold their last codeword
          if (nx_valid[s]) begin
            st[s].rem  <= sl_rem_out[s];
            st[s].code <= sl_code_out[s];
            st[s].prev <= sl_prev_out[s];
          end
        end
      end
    end
  end

  assign out_valid = st[STAGES-1].valid;
  assign out_code  = st[STAGES-1].code;

  logic unused_tail;
  assign unused_tail = ^{st[STAGES-1].rem, st[STAGES-1].prev};

endmodule
